cmp_seq: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle branch comparator in the pipelined MIPS core. It compares two WIDTH-bit operands against each other and compares A against zero. The comparison runs MSB-first, one CHUNK-bit slice per cycle, with early termination, and the unit has a selectable signed or unsigned mode. It sits beside the ID-stage hazard logic and serves wide or slow-path compares (e.g. trap/set-less-than extensions) through a start/done handshake with a flush.

---
 rtl/cmp_seq.sv | 152 +++++++++++++++
 tb/tb_cmp_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq.sv
// Multi-cycle MSB-first magnitude comparator: A vs B and A vs 0, CHUNK bits per
// cycle with early exit, signed or unsigned, start/done handshake with flush.
module cmp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       ab_o,
    output logic [1:0]       az_o,
    output logic [1:0]       state_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: a request is taken on a rising edge where start_i=1, ready_o=1
    // and flush_i=0; done_o is high for exactly the one cycle after the last
    // compare step, and ab_o/az_o hold their value until the next completion.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ab_dec_q, ab_dec_d;
    logic               az_dec_q, az_dec_d;
    logic               ab_gt_q, ab_gt_d;
    logic               az_gt_q, az_gt_d;
    logic [1:0]         ab_q, ab_d;
    logic [1:0]         az_q, az_d;

    logic [WIDTH-1:0]   msb_flip;
    logic [CHUNK-1:0]   a_sl, b_sl, z_sl;
    logic               ab_dec_n, az_dec_n, ab_gt_n, az_gt_n, finish;

    // Signed operands are mapped to offset binary so every slice compare is unsigned.
    assign msb_flip = {signed_mode_i, {(WIDTH-1){1'b0}}};

    assign a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign z_sl = z_q[int'(idx_q)*CHUNK +: CHUNK];

    assign ab_dec_n = ab_dec_q || (a_sl != b_sl);
    assign az_dec_n = az_dec_q || (a_sl != z_sl);
    assign ab_gt_n  = ab_dec_q ? ab_gt_q : (a_sl > b_sl);
    assign az_gt_n  = az_dec_q ? az_gt_q : (a_sl > z_sl);
    assign finish   = (ab_dec_n && az_dec_n) || (idx_q == '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        idx_d    = idx_q;
        ab_dec_d = ab_dec_q;
        az_dec_d = az_dec_q;
        ab_gt_d  = ab_gt_q;
        az_gt_d  = az_gt_q;
        ab_d     = ab_q;
        az_d     = az_q;

        case (state_q)
            IDLE, DONE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    state_d  = BUSY;
                    a_d      = a_i ^ msb_flip;
                    b_d      = b_i ^ msb_flip;
                    z_d      = msb_flip;
                    idx_d    = IDX_W'(N - 1);
                    ab_dec_d = 1'b0;
                    az_dec_d = 1'b0;
                    ab_gt_d  = 1'b0;
                    az_gt_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    ab_dec_d = ab_dec_n;
                    az_dec_d = az_dec_n;
                    ab_gt_d  = ab_gt_n;
                    az_gt_d  = az_gt_n;
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end
                    if (finish) begin
                        // Undecided after slice 0 means every slice matched: equal.
                        state_d = DONE;
                        ab_d    = ab_dec_n ? (ab_gt_n ? 2'b10 : 2'b00) : 2'b01;
                        az_d    = az_dec_n ? (az_gt_n ? 2'b10 : 2'b00) : 2'b01;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            idx_q    <= '0;
            ab_dec_q <= 1'b0;
            az_dec_q <= 1'b0;
            ab_gt_q  <= 1'b0;
            az_gt_q  <= 1'b0;
            ab_q     <= 2'b00;
            az_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            ab_dec_q <= ab_dec_d;
            az_dec_q <= az_dec_d;
            ab_gt_q  <= ab_gt_d;
            az_gt_q  <= az_gt_d;
            ab_q     <= ab_d;
            az_q     <= az_d;
        end
    end

    assign ready_o = (state_q != BUSY);
    assign busy_o  = (state_q == BUSY);
    assign done_o  = (state_q == DONE);
    assign ab_o    = ab_q;
    assign az_o    = az_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed plus random bench for cmp_seq: results, latency, handshake, flush
// and asynchronous reset, against an arithmetic reference model.
module tb_cmp_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [1:0]       ab;
    logic [1:0]       az;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    // expected {ab, az, latency}
    logic [11:0] exp_q[$];

    cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .signed_mode_i (signed_mode),
        .a_i           (a),
        .b_i           (b),
        .flush_i       (flush),
        .ready_o       (ready),
        .busy_o        (busy),
        .done_o        (done),
        .ab_o          (ab),
        .az_o          (az),
        .state_o       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: 1-based index from the top of the first nonzero slice
    function automatic int first_slice(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x;
        for (int i = 0; i < N; i++) begin
            if (t[WIDTH-1-i*CHUNK -: CHUNK] != '0) return i + 1;
        end
        return N;
    endfunction

    function automatic logic [1:0] enc(input logic gt, input logic eq);
        return eq ? 2'b01 : (gt ? 2'b10 : 2'b00);
    endfunction

    function automatic logic [11:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic s);
        logic [1:0] e_ab, e_az;
        int m_ab, m_az, m;
        if (s) begin
            e_ab = enc($signed(x) > $signed(y), x == y);
            e_az = enc($signed(x) > 32'sd0, x == '0);
        end else begin
            e_ab = enc(x > y, x == y);
            e_az = enc(x > '0, x == '0);
        end
        // A slice decides a result exactly when the operands differ in it
        m_ab = first_slice(x ^ y);
        m_az = first_slice(x);
        m = (m_ab > m_az) ? m_ab : m_az;
        return {e_ab, e_az, 8'(m)};
    endfunction

    // driver tasks; all drive/sample happens on the falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        logic [11:0] e;
        int k;
        k = 1;
        while (!done && k <= N + 2) begin
            chk("busy_in_flight", busy, 1'b1);
            chk("ready_in_flight", ready, 1'b0);
            @(negedge clk);
            k++;
        end
        e = exp_q.pop_front();
        if (!done) begin
            chk("done_timeout", done, 1'b1);
        end else begin
            chk("ab", ab, e[11:10]);
            chk("az", az, e[9:8]);
            chk("latency", k - 1, e[7:0]);
            chk("ready_in_done", ready, 1'b1);
            chk("busy_in_done", busy, 1'b0);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        chk("ready_before_start", ready, 1'b1);
        exp_q.push_back(model(x, y, s));
        start = 1'b1;
        a = x;
        b = y;
        signed_mode = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom();
        b = $urandom();
        signed_mode = $urandom_range(0, 1);
        wait_done();
    endtask

    initial begin
        logic [WIDTH-1:0] x, y;
        logic s;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ab", ab, 2'b00);
        chk("rst_az", az, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // directed cases; the third starts in the done cycle of the second
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        idle(1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0);
        idle(2);
        run_op(32'h0000_0005, 32'h0000_0003, 1'b1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        idle(1);

        // random stimulus biased toward shared upper slices
        for (int i = 0; i < 60; i++) begin
            x = $urandom();
            y = $urandom();
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: ;
                1: y = x;
                2: y = {x[WIDTH-1:CHUNK], y[CHUNK-1:0]};
                default: begin
                    x = WIDTH'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 1) y = WIDTH'($urandom_range(0, 255));
                end
            endcase
            run_op(x, y, s);
            idle($urandom_range(0, 2));
        end

        // flush in the second busy cycle with start held high
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0);
        idle(1);
        start = 1'b1;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("flush_busy1", busy, 1'b1);
        @(negedge clk);
        chk("flush_busy2", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", ready, 1'b1);
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_ab_hold", ab, 2'b10);
        chk("flush_az_hold", az, 2'b10);
        flush = 1'b0;
        exp_q.push_back(model('0, '0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        idle(1);

        // asynchronous reset between edges while busy
        start = 1'b1;
        a = '0;
        b = '0;
        signed_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_ab", ab, 2'b00);
        chk("areset_az", az, 2'b00);
        chk("areset_done", done, 1'b0);
        chk("areset_busy", busy, 1'b0);
        chk("areset_ready", ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
